// File: rtl/sm_arbiter.sv
// rtl/sm_arbiter.sv - two-requester round-robin front end for a shared sequential multiplier
//
// Purpose: arbitrates two requesters onto one sequential multiplier controller,
// captures the winner's operands, waits for completion (with a bounded timeout)
// and returns the product to the requester that was served.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req0/a0/b0          requester 0 request (held until gnt0) and operands
//   req1/a1/b1          requester 1 request (held until gnt1) and operands
//   gnt0, gnt1          one-cycle grant pulse (operands consumed)
//   res                 2*WIDTH product, holds last delivered value
//   res_vld0, res_vld1  one-cycle result-valid pulse per requester
//   timeout             one-cycle pulse alongside res_vld when the multiplier stalled
//   busy                high in any state other than IDLE
//   mul_start           one-cycle start pulse to the multiplier controller
//   mul_md, mul_mr      captured operands, stable from GRANT through WAIT
//   mul_done, mul_prod  multiplier completion and product, sampled in WAIT only

module sm_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [2*WIDTH-1:0] res,
    output logic               res_vld0,
    output logic               res_vld1,
    output logic               timeout,
    output logic               busy,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_md,
    output logic [WIDTH-1:0]   mul_mr,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_prod
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_last;
    logic                 r_owner;
    logic [7:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]     r_md;
    logic [WIDTH-1:0]     r_mr;
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_start;
    logic                 r_vld0;
    logic                 r_vld1;
    logic                 r_timeout;
    logic                 r_busy;

    logic                 w_pick;
    logic [7:0]           w_cnt_inc;

    // On a tie the requester that was not served last wins; otherwise the
    // single active requester wins (req1 alone picks 1, req0 alone picks 0).
    assign w_pick    = (req0 && req1) ? ~r_last : req1;

    // Saturating increment so a huge TIMEOUT can never be skipped by wrap-around.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // All outputs are registers updated together with the state they belong to,
    // so each pulse is high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_cnt     <= 8'd0;
            r_res     <= '0;
            r_md      <= '0;
            r_mr      <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_start   <= 1'b0;
            r_vld0    <= 1'b0;
            r_vld1    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_start   <= 1'b0;
            r_vld0    <= 1'b0;
            r_vld1    <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick;
                        r_md    <= w_pick ? a1 : a0;
                        r_mr    <= w_pick ? b1 : b0;
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                ST_GRANT: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= 8'd0;
                end

                ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // Completion is checked first so it beats a same-cycle timeout.
                    if (mul_done) begin
                        r_state   <= ST_DELIVER;
                        r_res     <= mul_prod;
                        r_vld0    <= ~r_owner;
                        r_vld1    <= r_owner;
                        r_timeout <= 1'b0;
                    end else if (w_cnt_inc >= LP_TIMEOUT) begin
                        r_state   <= ST_DELIVER;
                        r_res     <= '0;
                        r_vld0    <= ~r_owner;
                        r_vld1    <= r_owner;
                        r_timeout <= 1'b1;
                    end
                end

                ST_DELIVER: begin
                    r_state <= ST_IDLE;
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign mul_start = r_start;
    assign res_vld0  = r_vld0;
    assign res_vld1  = r_vld1;
    assign timeout   = r_timeout;
    assign busy      = r_busy;
    assign res       = r_res;
    assign mul_md    = r_md;
    assign mul_mr    = r_mr;

endmodule

// File: tb/tb_sm_arbiter.sv
// tb/tb_sm_arbiter.sv - directed self-checking bench for sm_arbiter

module tb_sm_arbiter;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0, req1;
    logic [WIDTH-1:0]   a0, b0, a1, b1;
    logic               gnt0, gnt1;
    logic [2*WIDTH-1:0] res;
    logic               res_vld0, res_vld1, timeout, busy, mul_start;
    logic [WIDTH-1:0]   mul_md, mul_mr;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    int n_tests = 0;
    int n_fail  = 0;

    sm_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .a0       (a0),
        .b0       (b0),
        .req1     (req1),
        .a1       (a1),
        .b1       (b1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .res      (res),
        .res_vld0 (res_vld0),
        .res_vld1 (res_vld1),
        .timeout  (timeout),
        .busy     (busy),
        .mul_start(mul_start),
        .mul_md   (mul_md),
        .mul_mr   (mul_mr),
        .mul_done (mul_done),
        .mul_prod (mul_prod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sits in WAIT for n cycles, raising mul_done with prod during the n-th.
    task automatic wait_done(input int n, input logic [2*WIDTH-1:0] prod);
        for (int i = 1; i <= n; i++) begin
            check("wait_busy", busy, 1);
            check("wait_no_vld", res_vld0 | res_vld1, 0);
            if (i == n) begin
                mul_done = 1'b1;
                mul_prod = prod;
            end
            tick();
        end
        mul_done = 1'b0;
        mul_prod = '0;
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        mul_done = 0; mul_prod = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1, mul_start}, 0);
        check("rst_vld", {res_vld0, res_vld1, timeout}, 0);
        check("rst_res", res, 0);
        check("rst_md", mul_md, 0);

        // Single request 3x5, operands changed to 7/7 during WAIT
        req0 = 1; a0 = 3; b0 = 5;
        tick();
        check("t1_gnt0", gnt0, 1);
        check("t1_gnt1", gnt1, 0);
        check("t1_start", mul_start, 1);
        check("t1_md", mul_md, 3);
        check("t1_mr", mul_mr, 5);
        req0 = 0; a0 = 7; b0 = 7;
        tick();
        check("t1_start_off", mul_start, 0);
        for (int i = 1; i <= 6; i++) begin
            check("t1_md_hold", mul_md, 3);
            check("t1_mr_hold", mul_mr, 5);
            if (i == 6) begin
                mul_done = 1; mul_prod = 8'd15;
            end
            tick();
        end
        mul_done = 0;
        check("t1_vld0", res_vld0, 1);
        check("t1_vld1", res_vld1, 0);
        check("t1_res", res, 15);
        check("t1_to", timeout, 0);
        tick();
        check("t1_idle", busy, 0);
        check("t1_vld_off", res_vld0, 0);
        check("t1_res_hold", res, 15);

        // Tie after reset: requester 0 first, then 1 after one IDLE cycle
        rst = 1; tick(); rst = 0;
        req0 = 1; req1 = 1; a0 = 2; b0 = 3; a1 = 4; b1 = 5;
        tick();
        check("t2_gnt0", gnt0, 1);
        check("t2_gnt1", gnt1, 0);
        check("t2_md", mul_md, 2);
        req0 = 0;
        tick();
        wait_done(1, 8'd6);
        check("t2_vld0", res_vld0, 1);
        check("t2_vld1_no", res_vld1, 0);
        check("t2_res0", res, 6);
        tick();
        check("t2_idle", busy, 0);
        check("t2_idle_gnt", gnt0 | gnt1, 0);
        tick();
        check("t2_gnt1b", gnt1, 1);
        check("t2_gnt0b", gnt0, 0);
        check("t2_md1", mul_md, 4);
        check("t2_mr1", mul_mr, 5);
        req1 = 0;
        tick();
        wait_done(1, 8'd20);
        check("t2_vld1", res_vld1, 1);
        check("t2_vld0_no", res_vld0, 0);
        check("t2_res1", res, 20);
        tick();

        // Fairness: both held across four operations, last served was 1
        req0 = 1; req1 = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t3_gnt0", gnt0, (k % 2) == 0);
            check("t3_gnt1", gnt1, (k % 2) == 1);
            check("t3_overlap", gnt0 & gnt1, 0);
            tick();
            wait_done(1, 8'(k + 40));
            check("t3_vld0", res_vld0, (k % 2) == 0);
            check("t3_vld1", res_vld1, (k % 2) == 1);
            check("t3_res", res, k + 40);
            tick();
            check("t3_idle", busy, 0);
            if (k == 3) begin
                req0 = 0; req1 = 0;
            end
            tick();
        end
        check("t3_stay_idle", busy, 0);

        // Timeout: mul_done never arrives
        req1 = 1; a1 = 1; b1 = 1;
        tick();
        check("t4_gnt1", gnt1, 1);
        req1 = 0;
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            check("t4_wait_to", timeout, 0);
            check("t4_wait_vld", res_vld1, 0);
            tick();
        end
        check("t4_vld1", res_vld1, 1);
        check("t4_res", res, 0);
        check("t4_to", timeout, 1);
        tick();
        check("t4_idle", busy, 0);
        check("t4_to_off", timeout, 0);

        // Completion on the timeout cycle wins
        req0 = 1; a0 = 15; b0 = 15;
        tick();
        check("t5_gnt0", gnt0, 1);
        req0 = 0;
        tick();
        wait_done(TIMEOUT, 8'd225);
        check("t5_vld0", res_vld0, 1);
        check("t5_res", res, 225);
        check("t5_to", timeout, 0);
        tick();

        // Reset mid-WAIT, then a stale mul_done
        req0 = 1; a0 = 2; b0 = 2;
        tick();
        req0 = 0;
        tick();
        tick();
        check("t6_in_wait", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        check("t6_busy", busy, 0);
        check("t6_vld", res_vld0 | res_vld1 | timeout, 0);
        check("t6_md", mul_md, 0);
        check("t6_res", res, 0);
        mul_done = 1; mul_prod = 8'd99;
        tick();
        check("t6_stale_busy", busy, 0);
        check("t6_stale_vld", res_vld0 | res_vld1, 0);
        tick();
        check("t6_stale_res", res, 0);
        mul_done = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
